// File: rtl/join_none_pkg.sv
// Shared types and defaults for the join_none thread launcher.
// Optional timestamp support is enabled with THREAD_TIMESTAMP_EN.
package join_none_pkg;

    localparam int CNT_W_DEFAULT       = 8;
    localparam int NUM_THREADS_DEFAULT = 2;

    typedef enum logic {
        TH_IDLE = 1'b0,
        TH_RUN  = 1'b1
    } th_state_t;

    typedef logic [CNT_W_DEFAULT-1:0] dur_t;

endpackage

// File: rtl/join_none_thread_launcher_thread.sv
// One countdown thread: loads its duration on fork while idle, pulses start/done, holds busy.
// THREAD_TIMESTAMP_EN adds start/done timestamp capture registers.
module join_none_thread
    import join_none_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fork_i,
    input  logic [CNT_W-1:0] dur_i,
`ifdef THREAD_TIMESTAMP_EN
    input  logic [CNT_W-1:0] ts_next_i,
    output logic [CNT_W-1:0] start_ts_o,
    output logic [CNT_W-1:0] done_ts_o,
`endif
    output logic             start_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             done_nx_o,
    output logic             run_nx_o
);

    th_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             done_q;
    logic             launch;
    logic             done_nx;
    logic             run_nx;

    assign launch = fork_i && (state_q == TH_IDLE);

    // Lookahead of next cycle's done/run, shared with the top for all_done.
    assign done_nx = launch ? (dur_i == '0)
                            : ((state_q == TH_RUN) && !done_q && (cnt_q == CNT_W'(1)));
    assign run_nx  = launch || ((state_q == TH_RUN) && !done_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TH_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= launch;
            done_q  <= done_nx;
            case (state_q)
                TH_IDLE: begin
                    if (fork_i) begin
                        state_q <= TH_RUN;
                        cnt_q   <= dur_i;
                    end
                end
                TH_RUN: begin
                    if (done_q) begin
                        state_q <= TH_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= TH_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef THREAD_TIMESTAMP_EN
    logic [CNT_W-1:0] start_ts_q;
    logic [CNT_W-1:0] done_ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_ts_q <= '0;
            done_ts_q  <= '0;
        end else begin
            if (launch) begin
                start_ts_q <= ts_next_i;
            end
            if (done_nx) begin
                done_ts_q <= ts_next_i;
            end
        end
    end

    assign start_ts_o = start_ts_q;
    assign done_ts_o  = done_ts_q;
`endif

    assign start_o   = start_q;
    assign done_o    = done_q;
    assign busy_o    = (state_q == TH_RUN);
    assign done_nx_o = done_nx;
    assign run_nx_o  = run_nx;

endmodule

// File: rtl/join_none_thread_launcher.sv
// fork/join_none launcher: one fork pulse starts all idle threads and releases the caller next cycle.
// THREAD_TIMESTAMP_EN adds a free-running ts_o plus per-thread start/done timestamps.
module join_none_thread_launcher
    import join_none_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fork_i,
    input  logic [NUM_THREADS*CNT_W-1:0] dur_i,
    output logic                         caller_go_o,
    output logic [NUM_THREADS-1:0]       start_o,
    output logic [NUM_THREADS-1:0]       done_o,
    output logic [NUM_THREADS-1:0]       busy_o,
    output logic                         all_done_o,
    output logic                         fork_err_o
`ifdef THREAD_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0]             ts_o,
    output logic [NUM_THREADS*CNT_W-1:0] start_ts_o,
    output logic [NUM_THREADS*CNT_W-1:0] done_ts_o
`endif
);

    logic [NUM_THREADS-1:0] done_nx;
    logic [NUM_THREADS-1:0] run_nx;
    logic                   caller_go_q;
    logic                   fork_err_q;
    logic                   all_done_q;
    logic                   all_done_d;

`ifdef THREAD_TIMESTAMP_EN
    logic [CNT_W-1:0] ts_q;
    logic [CNT_W-1:0] ts_next;

    assign ts_next = ts_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_next;
        end
    end

    assign ts_o = ts_q;
`endif

    for (genvar k = 0; k < NUM_THREADS; k++) begin : g_thread
        join_none_thread #(
            .CNT_W (CNT_W)
        ) u_thread (
            .clk        (clk),
            .rst_n      (rst_n),
            .fork_i     (fork_i),
            .dur_i      (dur_i[k*CNT_W +: CNT_W]),
`ifdef THREAD_TIMESTAMP_EN
            .ts_next_i  (ts_next),
            .start_ts_o (start_ts_o[k*CNT_W +: CNT_W]),
            .done_ts_o  (done_ts_o[k*CNT_W +: CNT_W]),
`endif
            .start_o    (start_o[k]),
            .done_o     (done_o[k]),
            .busy_o     (busy_o[k]),
            .done_nx_o  (done_nx[k]),
            .run_nx_o   (run_nx[k])
        );
    end

    // A thread finishing next cycle still shows as running; only non-finishing runners block all_done.
    assign all_done_d = (|done_nx) && !(|(run_nx & ~done_nx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            caller_go_q <= 1'b0;
            fork_err_q  <= 1'b0;
            all_done_q  <= 1'b0;
        end else begin
            caller_go_q <= fork_i;
            fork_err_q  <= fork_i && (|busy_o);
            all_done_q  <= all_done_d;
        end
    end

    assign caller_go_o = caller_go_q;
    assign fork_err_o  = fork_err_q;
    assign all_done_o  = all_done_q;

endmodule

// File: tb/tb_join_none_thread_launcher.sv
// Self-checking bench for join_none_thread_launcher: directed scenarios then randomized forks/resets.
module tb_join_none_thread_launcher;
    import join_none_pkg::*;

    localparam int NT = 2;
    localparam int CW = 8;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              fork_i = 1'b0;
    logic [NT*CW-1:0]  dur_i  = '0;
    logic              caller_go_o;
    logic [NT-1:0]     start_o;
    logic [NT-1:0]     done_o;
    logic [NT-1:0]     busy_o;
    logic              all_done_o;
    logic              fork_err_o;
`ifdef THREAD_TIMESTAMP_EN
    logic [CW-1:0]     ts_o;
    logic [NT*CW-1:0]  start_ts_o;
    logic [NT*CW-1:0]  done_ts_o;
`endif

    always #5 clk = ~clk;

    join_none_thread_launcher #(
        .NUM_THREADS (NT),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fork_i      (fork_i),
        .dur_i       (dur_i),
        .caller_go_o (caller_go_o),
        .start_o     (start_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .all_done_o  (all_done_o),
        .fork_err_o  (fork_err_o)
`ifdef THREAD_TIMESTAMP_EN
        ,
        .ts_o        (ts_o),
        .start_ts_o  (start_ts_o),
        .done_ts_o   (done_ts_o)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: each thread is an interval [st, dn] of cycles during which it is busy.
    int cyc;
    bit act [NT];
    int st  [NT];
    int dn  [NT];
    bit last_fork;
    bit last_err;
    int ts_m;
    int exp_sts [NT];
    int exp_dts [NT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit m_busy(input int k, input int c);
        return act[k] && (st[k] <= c) && (c <= dn[k]);
    endfunction

    task automatic check_outputs();
        logic [NT-1:0] es;
        logic [NT-1:0] ed;
        logic [NT-1:0] eb;
        bit            still_run;
        bit            ead;
        es = '0;
        ed = '0;
        eb = '0;
        still_run = 1'b0;
        for (int k = 0; k < NT; k++) begin
            es[k] = act[k] && (st[k] == cyc);
            ed[k] = act[k] && (dn[k] == cyc);
            eb[k] = m_busy(k, cyc);
            if (eb[k] && (dn[k] != cyc)) still_run = 1'b1;
        end
        ead = (|ed) && !still_run;
        chk("caller_go", 32'(caller_go_o), 32'(last_fork));
        chk("fork_err",  32'(fork_err_o),  32'(last_err));
        chk("start",     32'(start_o),     32'(es));
        chk("done",      32'(done_o),      32'(ed));
        chk("busy",      32'(busy_o),      32'(eb));
        chk("all_done",  32'(all_done_o),  32'(ead));
`ifdef THREAD_TIMESTAMP_EN
        chk("ts", 32'(ts_o), 32'(ts_m));
        for (int k = 0; k < NT; k++) begin
            chk("start_ts", 32'(start_ts_o[k*CW +: CW]), 32'(exp_sts[k]));
            chk("done_ts",  32'(done_ts_o[k*CW +: CW]),  32'(exp_dts[k]));
        end
`endif
    endtask

    task automatic step(input bit f, input logic [NT*CW-1:0] d);
        bit any_busy;
        int f_cyc;
        fork_i = f;
        dur_i  = d;
        @(posedge clk);
        f_cyc    = cyc;
        any_busy = 1'b0;
        for (int k = 0; k < NT; k++) begin
            if (m_busy(k, f_cyc)) any_busy = 1'b1;
        end
        if (f) begin
            for (int k = 0; k < NT; k++) begin
                if (!m_busy(k, f_cyc)) begin
                    act[k] = 1'b1;
                    st[k]  = f_cyc + 1;
                    dn[k]  = f_cyc + 1 + int'(d[k*CW +: CW]);
                end
            end
        end
        last_fork = f;
        last_err  = f && any_busy;
        cyc++;
        ts_m = (ts_m + 1) % 256;
        for (int k = 0; k < NT; k++) begin
            if (act[k] && st[k] == cyc) exp_sts[k] = ts_m;
            if (act[k] && dn[k] == cyc) exp_dts[k] = ts_m;
        end
        #1;
        fork_i = 1'b0;
        check_outputs();
    endtask

    task automatic rand_dur(output logic [NT*CW-1:0] d);
        for (int k = 0; k < NT; k++) d[k*CW +: CW] = CW'($urandom_range(0, 24));
    endtask

    task automatic idle_to(input int c);
        logic [NT*CW-1:0] d;
        while (cyc < c) begin
            rand_dur(d);
            step(1'b0, d);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NT; k++) begin
            act[k]     = 1'b0;
            exp_sts[k] = 0;
            exp_dts[k] = 0;
        end
        last_fork = 1'b0;
        last_err  = 1'b0;
        ts_m      = 0;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NT*CW-1:0] d;
        cyc = 0;
        ts_m = 0;
        for (int k = 0; k < NT; k++) begin
            act[k] = 1'b0; st[k] = 0; dn[k] = 0; exp_sts[k] = 0; exp_dts[k] = 0;
        end
        last_fork = 1'b0;
        last_err  = 1'b0;

        // Basic: thread0=20, thread1=30, fork at 5.
        do_reset();
        idle_to(5);
        step(1'b1, {8'd30, 8'd20});
        idle_to(40);

        // Zero duration on thread 0.
        do_reset();
        idle_to(2);
        step(1'b1, {8'd3, 8'd0});
        idle_to(10);

        // Re-fork while thread 1 still busy.
        do_reset();
        idle_to(5);
        step(1'b1, {8'd30, 8'd20});
        idle_to(30);
        step(1'b1, {8'd30, 8'd20});
        idle_to(60);

        // Equal durations: one all_done pulse.
        do_reset();
        step(1'b1, {8'd10, 8'd10});
        idle_to(15);

        // Fork in the exact cycle a thread reports done, then back-to-back forks.
        do_reset();
        idle_to(1);
        step(1'b1, {8'd9, 8'd4});
        idle_to(6);
        step(1'b1, {8'd2, 8'd1});
        step(1'b1, {8'd0, 8'd0});
        step(1'b1, {8'd5, 8'd3});
        idle_to(25);

        // Reset mid-run.
        do_reset();
        idle_to(5);
        step(1'b1, {8'd30, 8'd20});
        idle_to(15);
        do_reset();
        idle_to(50);

        // Randomized forks, durations and occasional resets.
        do_reset();
        for (int i = 0; i < 700; i++) begin
            rand_dur(d);
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 6) == 0, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
